pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
- Controller that owns the 16-bit PWM write bus (d/sel) and sequences reconfiguration of the PWM datapath.
- Accepts a request {top, target compare, step} over a valid/ready handshake and writes the new top.
- Then ramps the compare register toward the target by `step`, one update per N PWM periods. Updates land only at period wrap, so there are no glitched pulses.
- Sits between software-facing config logic and the PWM timer; it is the only driver of the timer's sel/d.

Parameters:
- PERIODS_PER_STEP, 1, PWM periods between successive compare updates (1..255).

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_top  in  16  new top value
- req_cmp  in  16  target compare value
- req_step  in  16  compare increment per update; 0 = jump directly to target
- pwm_cnt  in  16  timer counter value
- pwm_top  in  16  timer top value
- pwm_cmp  in  16  timer compare value
- pwm_d  out  16  write data to timer
- pwm_sel  out  2  write select to timer: 0 idle, 1 cmp, 2 top, 3 cnt
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when compare reaches target

Behaviour:
- Reset (nrst=0 at posedge): state=IDLE, cur_cmp=0, tgt=0, step=0, div_cnt=0, done=0.
  - Outputs while in reset/IDLE: pwm_sel=0, pwm_d=0, req_ready=1, busy=0.
  - Reset mid-sequence abandons the sequence; no further timer writes are issued.
- Handshake: transfer occurs when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - On transfer, capture tgt<=req_cmp, top_r<=req_top, step<=req_step, cur_cmp<=pwm_cmp; go to WR_TOP.
- pwm_sel and pwm_d are combinational from the state registers and pwm_cnt/pwm_top. The write therefore lands on the same edge that is decided.
- wrap = (pwm_cnt >= pwm_top), i.e. the timer loads 0 on the next edge.
- States:
  - IDLE: wait for transfer.
  - WR_TOP: drive sel=2, d=top_r for one cycle.
    - Next state: WR_CNT if the feature is enabled.
    - Otherwise DONE if cur_cmp==tgt, else RAMP.
  - WR_CNT (feature only): sel=3, d=0 for one cycle; then DONE or RAMP, same rule as WR_TOP.
  - RAMP: compare updates.
    - On each wrap cycle, div_cnt increments.
    - When div_cnt==PERIODS_PER_STEP-1 on a wrap cycle: drive sel=1, d=nxt, set cur_cmp<=nxt, div_cnt<=0.
    - If nxt==tgt, go to DONE.
    - No write on non-wrap cycles.
  - DONE: done=1 for one cycle, then IDLE.
- nxt computation, in 17-bit arithmetic (no wrap-around):
  - cur<tgt: nxt = min(cur+step, tgt).
  - cur>tgt: nxt = max(cur−step, tgt), floored at tgt with no underflow.
  - step==0: nxt = tgt.
- Boundaries:
  - top=0: wrap is true every cycle, so one update per PERIODS_PER_STEP cycles.
  - cur==tgt at capture: only the top write (and cnt write) are issued, then DONE.
  - req_valid held high during busy: ignored until IDLE; the first accept happens the cycle after DONE.
  - An unchanged req_top is still written.

Optional Feature:
- Macro PWM_RAMP_CTRL_RESTART_EN.
- Defined: after WR_TOP, a WR_CNT write of 0 restarts the period immediately, so the new top applies from a clean period.
- Undefined: the WR_CNT state does not exist; the counter continues, and if pwm_cnt > new top it wraps on the next cycle via the timer's own rule.

Decomposition:
- Shared package pwm_pkg:
  - pwm_sel_e enum {SEL_IDLE=2'd0, SEL_CMP=2'd1, SEL_TOP=2'd2, SEL_CNT=2'd3}.
  - PWM_W=16.
  - ramp_state_e {IDLE, WR_TOP, WR_CNT, RAMP, DONE}.
- One sub-module: pwm_ramp_step. Purely combinational; takes cur, tgt, step and produces nxt and at_tgt. It is reused by future fade blocks.

Test Plan:
- Reset: nrst=0 for 2 cycles mid-RAMP -> pwm_sel=0, busy=0, req_ready=1, no writes after reset.
- Ramp up: pwm_cmp=0, request top=9, cmp=10, step=4 -> sel=2/d=9 once, then sel=1 writes 4, 8, 10 on three successive wraps (cnt=9), done pulse, IDLE.
- Ramp down with floor: cur=10, tgt=3, step=4 -> writes 6, 3 (not −1), then done.
- step=0 and cur==tgt: step=0, tgt=7 -> single cmp write of 7 at the first wrap. A second request with tgt==cur -> top write only, then done.
- Divider: PERIODS_PER_STEP=3, top=4 -> cmp writes spaced exactly 15 cycles apart; request asserted while busy is not accepted until the cycle after done.
- Restart (macro defined): pwm_cnt=50, new top=20 -> sel=2 then sel=3/d=0 on the next cycle, counter reads 0, and ramp updates align to the new period.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types for the PWM ramp controller and related fade blocks.
package pwm_pkg;

    localparam int unsigned PWM_W = 16;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_CMP  = 2'd1,
        SEL_TOP  = 2'd2,
        SEL_CNT  = 2'd3
    } pwm_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_TOP,
        WR_CNT,
        RAMP,
        DONE
    } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_step.sv
// One ramp step toward a target: nxt = cur moved by step, clamped at tgt.
module pwm_ramp_step
    import pwm_pkg::*;
(
    input  logic [PWM_W-1:0] i_cur,
    input  logic [PWM_W-1:0] i_tgt,
    input  logic [PWM_W-1:0] i_step,
    output logic [PWM_W-1:0] o_nxt,
    output logic             o_at_tgt
);

    logic [PWM_W:0] w_sum;
    logic [PWM_W:0] w_diff;

    // 17-bit arithmetic so overflow/borrow shows up in the top bit instead of wrapping
    assign w_sum  = {1'b0, i_cur} + {1'b0, i_step};
    assign w_diff = {1'b0, i_cur} - {1'b0, i_step};

    always_comb begin
        o_at_tgt = (i_cur == i_tgt);
        if (i_step == '0 || o_at_tgt) begin
            o_nxt = i_tgt;
        end else if (i_cur < i_tgt) begin
            o_nxt = (w_sum >= {1'b0, i_tgt}) ? i_tgt : w_sum[PWM_W-1:0];
        end else begin
            o_nxt = (w_diff[PWM_W] || w_diff[PWM_W-1:0] <= i_tgt) ? i_tgt : w_diff[PWM_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM reconfiguration sequencer: writes top, then ramps compare at period wraps.
// Optional counter restart after the top write: PWM_RAMP_CTRL_RESTART_EN.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned PERIODS_PER_STEP = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PWM_W-1:0] req_top,
    input  logic [PWM_W-1:0] req_cmp,
    input  logic [PWM_W-1:0] req_step,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] pwm_top,
    input  logic [PWM_W-1:0] pwm_cmp,
    output logic [PWM_W-1:0] pwm_d,
    output logic [1:0]       pwm_sel,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] DIV_LAST = 8'(PERIODS_PER_STEP - 1);

    ramp_state_e      r_state;
    logic [PWM_W-1:0] r_top;
    logic [PWM_W-1:0] r_tgt;
    logic [PWM_W-1:0] r_step;
    logic [PWM_W-1:0] r_cur;
    logic [7:0]       r_div;
    logic             r_done;

    logic [PWM_W-1:0] w_nxt;
    logic             w_at_tgt;
    logic             w_wrap;
    logic             w_upd;

    pwm_ramp_step u_step (
        .i_cur    (r_cur),
        .i_tgt    (r_tgt),
        .i_step   (r_step),
        .o_nxt    (w_nxt),
        .o_at_tgt (w_at_tgt)
    );

    assign w_wrap    = (pwm_cnt >= pwm_top);
    assign w_upd     = (r_state == RAMP) && w_wrap && (r_div == DIV_LAST);
    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

    // Writes are decided and issued in the same cycle so they land on that edge
    always_comb begin
        pwm_sel = SEL_IDLE;
        pwm_d   = '0;
        case (r_state)
            WR_TOP: begin
                pwm_sel = SEL_TOP;
                pwm_d   = r_top;
            end
            WR_CNT: begin
                pwm_sel = SEL_CNT;
                pwm_d   = '0;
            end
            RAMP: begin
                if (w_upd) begin
                    pwm_sel = SEL_CMP;
                    pwm_d   = w_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_top   <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_cur   <= '0;
            r_div   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_tgt   <= req_cmp;
                        r_top   <= req_top;
                        r_step  <= req_step;
                        r_cur   <= pwm_cmp;
                        r_div   <= '0;
                        r_state <= WR_TOP;
                    end
                end
`ifdef PWM_RAMP_CTRL_RESTART_EN
                WR_TOP: r_state <= WR_CNT;
                WR_CNT: begin
`else
                WR_TOP: begin
`endif
                    if (w_at_tgt) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RAMP;
                    end
                end
                RAMP: begin
                    if (w_wrap) begin
                        if (r_div == DIV_LAST) begin
                            r_cur <= w_nxt;
                            r_div <= '0;
                            if (w_nxt == r_tgt) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with a behavioural PWM timer and ramp model.
module tb_pwm_ramp_ctrl;

    localparam int P = 3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_top = '0, req_cmp = '0, req_step = '0;
    logic [15:0] t_cnt = 16'd0, t_top = 16'd9, t_cmp = 16'd0;
    logic [15:0] pwm_d;
    logic [1:0]  pwm_sel;
    logic        busy, done;

    int total = 0, bad = 0;
    int cyc = 0, done_cyc = -100, last_cmp_cyc = -1, last_top_cyc = -100;
    int writes = 0, cmp_writes = 0;
    logic [17:0] q[$];

    pwm_ramp_ctrl #(.PERIODS_PER_STEP(P)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_top(req_top), .req_cmp(req_cmp), .req_step(req_step),
        .pwm_cnt(t_cnt), .pwm_top(t_top), .pwm_cmp(t_cmp),
        .pwm_d(pwm_d), .pwm_sel(pwm_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: counts up, reloads 0 once cnt >= top, accepts bus writes
    always @(posedge clk) begin
        if (pwm_sel == 2'd3)      t_cnt <= pwm_d;
        else if (t_cnt >= t_top)  t_cnt <= 16'd0;
        else                      t_cnt <= t_cnt + 16'd1;
        if (pwm_sel == 2'd2) t_top <= pwm_d;
        if (pwm_sel == 2'd1) t_cmp <= pwm_d;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected bus traffic for one request: top write, optional restart, compare steps, done marker
    task automatic push_expect(input logic [15:0] top, input logic [15:0] tgt,
                               input logic [15:0] step, input logic [15:0] cur);
        int c, t, s;
        logic [15:0] v;
        c = int'(cur); t = int'(tgt); s = int'(step);
        q.push_back({2'd2, top});
`ifdef PWM_RAMP_CTRL_RESTART_EN
        q.push_back({2'd3, 16'd0});
`endif
        while (c != t) begin
            if (s == 0)     c = t;
            else if (c < t) c = (c + s > t) ? t : c + s;
            else            c = (c - s < t) ? t : c - s;
            v = 16'(c);
            q.push_back({2'd1, v});
        end
        q.push_back(18'd0);
    endtask

    // Monitor: every bus write or done pulse must match the head of the queue
    always @(negedge clk) begin
        if (nrst && (pwm_sel != 2'd0 || done)) begin
            logic [17:0] obs, exp;
            obs = done ? 18'd0 : {pwm_sel, pwm_d};
            if (pwm_sel != 2'd0) writes++;
            if (done) done_cyc = cyc;
            if (q.size() == 0) begin
                chk("unexpected_event", 32'(obs), 32'h3ffff);
            end else begin
                exp = q.pop_front();
                chk("bus_event", 32'(obs), 32'(exp));
            end
            if (pwm_sel == 2'd2) begin
                last_cmp_cyc = -1;
                last_top_cyc = cyc;
            end
            if (pwm_sel == 2'd3) chk("restart_follows_top", 32'(cyc), 32'(last_top_cyc + 1));
            if (pwm_sel == 2'd1) begin
                cmp_writes++;
                if (last_cmp_cyc >= 0)
                    chk("cmp_spacing", 32'(cyc - last_cmp_cyc), 32'(P * (int'(t_top) + 1)));
                last_cmp_cyc = cyc;
            end
        end
    end

    // Caller is at posedge+#1; returns the cycle on which ready was seen with valid high
    task automatic send(input logic [15:0] top, input logic [15:0] cmp,
                        input logic [15:0] step, output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        req_valid = 1'b1; req_top = top; req_cmp = cmp; req_step = step;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (req_ready) begin
                push_expect(top, cmp, step, t_cmp);
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, w0, tgt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(pwm_sel), 32'd0);
        chk("rst_d", 32'(pwm_d), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        send(16'd9, 16'd10, 16'd4, acc);  wait_idle();   // up: 4, 8, 10
        send(16'd9, 16'd3, 16'd4, acc);   wait_idle();   // down with floor: 6, 3
        send(16'd9, 16'd7, 16'd0, acc);   wait_idle();   // jump: 7
        send(16'd9, 16'd7, 16'd5, acc);   wait_idle();   // cur==tgt: top only
        send(16'd0, 16'd12, 16'd2, acc);  wait_idle();   // top=0: wrap every cycle

        // Held request while busy is taken on the cycle after done
        send(16'd4, 16'd20, 16'd5, acc);
        send(16'd4, 16'd2, 16'd7, acc);
        chk("accept_after_done", 32'(acc), 32'(done_cyc + 1));
        wait_idle();

        // Shrink top while the counter is well above it
        send(16'd60, t_cmp, 16'd0, acc); wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (t_cnt == 16'd50) break;
        end
        @(posedge clk); #1;
        send(16'd20, 16'(int'(t_cmp) + 9), 16'd3, acc); wait_idle();

        // Reset mid-ramp abandons the sequence
        w0 = cmp_writes;
        send(16'd4, 16'(int'(t_cmp) + 30), 16'd1, acc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmp_writes >= w0 + 2) break;
        end
        chk("ramp_started", 32'(cmp_writes >= w0 + 2), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_sel", 32'(pwm_sel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b1;
        w0 = writes;
        repeat (40) @(negedge clk);
        chk("no_writes_after_reset", 32'(writes - w0), 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 8; n++) begin
            logic [15:0] st;
            tgt = int'($urandom_range(0, 40));
            st = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            send(16'($urandom_range(0, 12)), 16'(tgt), st, acc);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
